// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver with per-frame snapshot and inter-digit guard blanking.
// Optional digit blinking is compiled in when SEG_BLINK_EN is defined.
module seg7_scan_driver #(
    parameter int SCAN_DIV   = 100_000,
    parameter int GUARD_CYC  = 1_000,
    parameter int ACTIVE_LOW = 0,
    parameter int BLINK_DIV  = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_data,
    input  logic [7:0]  dp_mask,
    input  logic        disp_en,
`ifdef SEG_BLINK_EN
    input  logic [7:0]  blink_mask,
`endif
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_sync
);

    localparam int              DIV_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] GUARD_V = DIV_W'(GUARD_CYC);
    localparam logic            INV     = (ACTIVE_LOW != 0);

    if (SCAN_DIV < 2 || GUARD_CYC < 0 || GUARD_CYC >= SCAN_DIV || BLINK_DIV < 1) begin : g_param_chk
        $error("seg7_scan_driver: illegal parameter combination");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       dig_idx;
    logic [31:0]      snap_data;
    logic [7:0]       snap_dp;
    logic             tick;
    logic             frame_end;
    logic             blink_off;
    logic             blank;
    logic [7:0]       an_nxt;
    logic [6:0]       seg_nxt;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        case (h)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    assign tick      = (div_cnt == DIV_MAX);
    assign frame_end = tick && (dig_idx == 3'd7);

`ifdef SEG_BLINK_EN
    localparam int              BLK_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLK_MAX) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Mask is used live so the host can start/stop blinking mid-frame.
    assign blink_off = blink_phase && blink_mask[dig_idx];
`else
    assign blink_off = 1'b0;
`endif

    assign blank   = (div_cnt < GUARD_V) || !disp_en || blink_off;
    assign seg_nxt = hex_decode(snap_data[{dig_idx, 2'b00} +: 4]);

    for (genvar i = 0; i < 8; i++) begin : g_an
        assign an_nxt[i] = !blank && (dig_idx == 3'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt    <= '0;
            dig_idx    <= 3'd0;
            snap_data  <= 32'h0;
            snap_dp    <= 8'h00;
            frame_sync <= 1'b0;
            an         <= {8{INV}};
            seg        <= {7{INV}};
            dp         <= INV;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                dig_idx <= dig_idx + 3'd1;
            // Snapshot only at the frame boundary so a frame never mixes two words.
            if (frame_end) begin
                snap_data <= disp_data;
                snap_dp   <= dp_mask;
            end
            frame_sync <= frame_end;
            an         <= an_nxt ^ {8{INV}};
            seg        <= seg_nxt ^ {7{INV}};
            dp         <= snap_dp[dig_idx] ^ INV;
        end
    end

endmodule
